// File: rtl/ram_burst_master_pkg.sv
// ram_burst_master_pkg
// Shared definitions for the burst master and its data_memory responder:
// FSM state encoding, operation codes and default bus/memory sizing.
package ram_burst_master_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 1000;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_RD_DRAIN = 3'd2,
      ST_WR       = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if
// Bundles every non-clock signal of the burst master:
//   control   : start, op, base_addr, len -> busy, done, err
//   read out  : rd_data, rd_valid -> rd_ready
//   write in  : wr_data, wr_valid -> wr_ready
//   memory    : mem_addr, mem_read, mem_write, mem_wdata -> mem_rdata
// modport master is the burst master's view; modport slave is the
// view of everything around it (controller, consumer, producer, memory).
interface ram_burst_master_if
   import ram_burst_master_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              start;
   logic              op;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic              done;
   logic              err;

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  start, op, base_addr, len, rd_ready, wr_data, wr_valid, mem_rdata,
      output busy, done, err, rd_data, rd_valid, wr_ready,
             mem_addr, mem_read, mem_write, mem_wdata
   );

   modport slave (
      output start, op, base_addr, len, rd_ready, wr_data, wr_valid, mem_rdata,
      input  busy, done, err, rd_data, rd_valid, wr_ready,
             mem_addr, mem_read, mem_write, mem_wdata
   );

endinterface

// File: rtl/ram_burst_master_rd_out_reg.sv
// ram_burst_master_rd_out_reg
// One-entry valid/ready output register for read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i and mark the entry valid
//   clear_i    : entry consumed with nothing new behind it, drop valid
//   data_i     : word to capture
//   data_o     : held word (keeps its value after valid drops)
//   valid_o    : entry holds an unconsumed word
module ram_burst_master_rd_out_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
);

   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   // A load wins over a clear: in the streaming case the consumed word is
   // replaced by the next one in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
// Turns a single start request into a sequential read or write burst on
// the single-port data_memory bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_burst_master_if.master (control, read stream,
//                write stream and memory bus)
module ram_burst_master
   import ram_burst_master_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input logic                clk,
   input logic                rst_n,
   ram_burst_master_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [ADDR_W:0]   end_addr;
   logic              range_bad;
   logic              rd_valid;
   logic              capture;
   logic              drain_pop;

   // One extra bit so base_addr+len cannot overflow before the compare.
   assign end_addr  = {1'b0, bus.base_addr} + {1'b0, bus.len};
   assign range_bad = end_addr > (ADDR_W+1)'(DEPTH);

   // The output register can take a new word whenever it is empty or its
   // current word is being handed over this cycle.
   assign capture   = (state_q == ST_RD) && (!rd_valid || bus.rd_ready);
   assign drain_pop = (state_q == ST_RD_DRAIN) && bus.rd_ready;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (range_bad) begin
                  err_d = 1'b1;
               end else if (bus.len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  mem_addr_d = bus.base_addr;
                  cnt_d      = bus.len;
                  state_d    = (bus.op == OP_WR) ? ST_WR : ST_RD;
               end
            end
         end
         ST_RD: begin
            if (capture) begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - ADDR_W'(1);
               if (cnt_q == ADDR_W'(1)) state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
            if (bus.rd_ready) state_d = ST_DONE;
         end
         ST_WR: begin
            if (bus.wr_valid) begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - ADDR_W'(1);
               if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   ram_burst_master_rd_out_reg #(
      .DATA_W (DATA_W)
   ) u_rd_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (capture),
      .clear_i (drain_pop),
      .data_i  (bus.mem_rdata),
      .data_o  (bus.rd_data),
      .valid_o (rd_valid)
   );

   // Strobes decode the registered state only; the write strobe and data
   // pass straight through so a handshake commits at the same edge.
   assign bus.rd_valid  = rd_valid;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = err_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_read  = (state_q == ST_RD);
   assign bus.wr_ready  = (state_q == ST_WR);
   assign bus.mem_write = (state_q == ST_WR) && bus.wr_valid;
   assign bus.mem_wdata = bus.wr_data;

endmodule
